// File: rtl/hack_clock_ctrl.sv
// hack_clock_ctrl: run/halt/step/burst controller for the Hack CPU clock.
// Generates a registered single-cycle clock-enable (cpu_ce) on the board
// clock instead of handing the CPU a divided clock.
module hack_clock_ctrl #(
  parameter int CNT_W   = 32,
  parameter int BURST_W = 16
) (
  input  logic               clk_in,
  input  logic               reset_n,
  input  logic               run_req,
  input  logic               halt_req,
  input  logic               step_req,
  input  logic               burst_req,
  input  logic [BURST_W-1:0] burst_len,
  input  logic [CNT_W-1:0]   rate_div,
  output logic               cpu_ce,
  output logic [1:0]         state,
  output logic               running,
  output logic [31:0]        tick_count
);

  typedef enum logic [1:0] {
    HALTED = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2,
    BURST  = 2'd3
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic               ce_d;
  logic [CNT_W-1:0]   prescaler;
  logic [CNT_W-1:0]   prescaler_d;
  logic [BURST_W-1:0] remaining;
  logic [BURST_W-1:0] remaining_d;
  logic [CNT_W-1:0]   div_latched;
  logic [CNT_W-1:0]   div_latched_d;
  logic [CNT_W-1:0]   div_eff_in;
  logic               tick_due;

  // A zero divider is treated as one so free-run never stalls.
  assign div_eff_in = (rate_div == '0) ? CNT_W'(1) : rate_div;

  // A tick is due once the prescaler has counted a full divider period.
  assign tick_due = (prescaler == div_latched - CNT_W'(1));

  // Next-state and next-output decode; every edge re-evaluates the requests.
  always_comb begin
    state_d       = state_q;
    ce_d          = 1'b0;
    prescaler_d   = prescaler;
    remaining_d   = remaining;
    div_latched_d = div_latched;
    unique case (state_q)
      HALTED: begin
        if (halt_req) begin
          state_d = HALTED;
        end else if (run_req) begin
          state_d       = RUN;
          prescaler_d   = '0;
          div_latched_d = div_eff_in;
        end else if (burst_req && (burst_len != '0)) begin
          state_d       = BURST;
          remaining_d   = burst_len;
          prescaler_d   = '0;
          div_latched_d = div_eff_in;
        end else if (step_req) begin
          state_d = STEP;
          ce_d    = 1'b1;
        end
      end
      RUN: begin
        if (halt_req || !run_req) begin
          state_d = HALTED;
        end else if (tick_due) begin
          ce_d        = 1'b1;
          prescaler_d = '0;
        end else begin
          prescaler_d = prescaler + CNT_W'(1);
        end
      end
      STEP: begin
        state_d = HALTED;
      end
      BURST: begin
        if (halt_req) begin
          state_d = HALTED;
        end else if (tick_due) begin
          ce_d        = 1'b1;
          prescaler_d = '0;
          remaining_d = remaining - BURST_W'(1);
          if (remaining == BURST_W'(1)) begin
            state_d = HALTED;
          end
        end else begin
          prescaler_d = prescaler + CNT_W'(1);
        end
      end
      default: begin
        state_d = HALTED;
      end
    endcase
  end

  // State, enable and counters register; synchronous active-low reset wins.
  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      state_q     <= HALTED;
      cpu_ce      <= 1'b0;
      tick_count  <= '0;
      prescaler   <= '0;
      remaining   <= '0;
      div_latched <= CNT_W'(1);
    end else begin
      state_q     <= state_d;
      cpu_ce      <= ce_d;
      tick_count  <= tick_count + {31'b0, ce_d};
      prescaler   <= prescaler_d;
      remaining   <= remaining_d;
      div_latched <= div_latched_d;
    end
  end

  assign state   = state_q;
  assign running = (state_q != HALTED);

endmodule

// File: tb/tb_hack_clock_ctrl.sv
// tb_hack_clock_ctrl: scoreboard bench for hack_clock_ctrl. Stimulus pushes
// the reference model's expectation for each edge; a monitor pops and checks.
module tb_hack_clock_ctrl;

  logic        clk_in = 1'b0;
  logic        reset_n = 1'b0;
  logic        run_req = 1'b0;
  logic        halt_req = 1'b0;
  logic        step_req = 1'b0;
  logic        burst_req = 1'b0;
  logic [15:0] burst_len = '0;
  logic [31:0] rate_div = '0;
  logic        cpu_ce;
  logic [1:0]  state;
  logic        running;
  logic [31:0] tick_count;

  typedef struct {
    logic [1:0]  st;
    logic        ce;
    logic        run;
    logic [31:0] ticks;
  } exp_t;

  exp_t sb_queue[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: mode plus edges-since-entry, ticks where that count is
  // a multiple of the divider; bursts end when the issued count hits N.
  int unsigned m_state = 0;
  int unsigned m_edges = 0;
  int unsigned m_div = 1;
  int unsigned m_total = 0;
  int unsigned m_done = 0;
  logic        m_ce = 1'b0;
  logic [31:0] m_ticks = '0;

  hack_clock_ctrl #(.CNT_W(32), .BURST_W(16)) dut (
    .clk_in     (clk_in),
    .reset_n    (reset_n),
    .run_req    (run_req),
    .halt_req   (halt_req),
    .step_req   (step_req),
    .burst_req  (burst_req),
    .burst_len  (burst_len),
    .rate_div   (rate_div),
    .cpu_ce     (cpu_ce),
    .state      (state),
    .running    (running),
    .tick_count (tick_count)
  );

  // Board clock, 10 time-unit period.
  always #5 clk_in = ~clk_in;

  // Advance the model by one edge using the inputs about to be sampled.
  task automatic modelEdge(input bit rst_n, input bit run, input bit halt,
                           input bit step, input bit burst,
                           input int unsigned len, input int unsigned div);
    m_ce = 1'b0;
    if (!rst_n) begin
      m_state = 0; m_edges = 0; m_div = 1; m_total = 0; m_done = 0;
      m_ticks = '0;
      return;
    end
    case (m_state)
      0: begin
        if (halt) begin
        end else if (run) begin
          m_state = 1; m_edges = 0; m_div = (div == 0) ? 1 : div;
        end else if (burst && len != 0) begin
          m_state = 3; m_edges = 0; m_div = (div == 0) ? 1 : div;
          m_total = len; m_done = 0;
        end else if (step) begin
          m_state = 2; m_ce = 1'b1;
        end
      end
      1: begin
        if (halt || !run) m_state = 0;
        else begin
          m_edges++;
          m_ce = ((m_edges % m_div) == 0);
        end
      end
      2: m_state = 0;
      default: begin
        if (halt) m_state = 0;
        else begin
          m_edges++;
          if ((m_edges % m_div) == 0) begin
            m_ce = 1'b1;
            m_done++;
            if (m_done == m_total) m_state = 0;
          end
        end
      end
    endcase
    m_ticks = m_ticks + (m_ce ? 32'd1 : 32'd0);
  endtask

  // Drive one cycle of inputs at the falling edge and queue the expectation.
  task automatic applyStimulus(input bit rst_n, input bit run, input bit halt,
                               input bit step, input bit burst,
                               input int unsigned len, input int unsigned div);
    exp_t e;
    @(negedge clk_in);
    reset_n   = rst_n;
    run_req   = run;
    halt_req  = halt;
    step_req  = step;
    burst_req = burst;
    burst_len = 16'(len);
    rate_div  = div;
    modelEdge(rst_n, run, halt, step, burst, len, div);
    e.st    = 2'(m_state);
    e.ce    = m_ce;
    e.run   = (m_state != 0);
    e.ticks = m_ticks;
    sb_queue.push_back(e);
  endtask

  // Compare one expectation against the DUT outputs.
  task automatic checkOutput(input exp_t e);
    bit bad;
    bad = 1'b0;
    vectors++;
    if (state !== e.st) begin
      $display("[TB] FAIL state at %0t: got %0d want %0d", $time, state, e.st);
      bad = 1'b1;
    end
    if (cpu_ce !== e.ce) begin
      $display("[TB] FAIL cpu_ce at %0t: got %b want %b", $time, cpu_ce, e.ce);
      bad = 1'b1;
    end
    if (running !== e.run) begin
      $display("[TB] FAIL running at %0t: got %b want %b", $time, running, e.run);
      bad = 1'b1;
    end
    if (tick_count !== e.ticks) begin
      $display("[TB] FAIL tick_count at %0t: got %0d want %0d", $time, tick_count, e.ticks);
      bad = 1'b1;
    end
    if (bad) miscompares++;
  endtask

  // Monitor: shortly after each rising edge, check the outcome of that edge.
  initial begin
    forever begin
      @(posedge clk_in);
      #2;
      if (sb_queue.size() > 0) checkOutput(sb_queue.pop_front());
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Directed scenarios followed by a randomized phase.
  initial begin
    bit run_lvl;
    int unsigned div_lvl;
    int pending;

    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // Three single steps separated by idle cycles.
    repeat (3) begin
      applyStimulus(1, 0, 0, 1, 0, 0, 0);
      repeat (3) applyStimulus(1, 0, 0, 0, 0, 0, 0);
    end

    // Free run at divider 4 for 20 edges, then release.
    repeat (20) applyStimulus(1, 1, 0, 0, 0, 0, 4);
    repeat (6) applyStimulus(1, 0, 0, 0, 0, 0, 4);

    // Burst of 7 at divider 0 (treated as 1).
    applyStimulus(1, 0, 0, 0, 1, 7, 0);
    repeat (10) applyStimulus(1, 0, 0, 0, 0, 0, 0);

    // Burst of 10 at divider 3, halted on the edge the 4th tick is due.
    applyStimulus(1, 0, 0, 0, 1, 10, 3);
    repeat (11) applyStimulus(1, 0, 0, 0, 0, 0, 3);
    applyStimulus(1, 0, 1, 0, 0, 0, 3);
    repeat (5) applyStimulus(1, 0, 0, 0, 0, 0, 3);

    // Simultaneous requests: run wins; then a zero-length burst alone.
    applyStimulus(1, 1, 0, 1, 1, 5, 2);
    repeat (6) applyStimulus(1, 1, 0, 0, 0, 0, 2);
    applyStimulus(1, 0, 0, 0, 0, 0, 2);
    applyStimulus(1, 0, 0, 0, 1, 0, 2);
    repeat (3) applyStimulus(1, 0, 0, 0, 0, 0, 2);

    // Reset for one edge mid-run at divider 2, run held high throughout.
    repeat (7) applyStimulus(1, 1, 0, 0, 0, 0, 2);
    applyStimulus(0, 1, 0, 0, 0, 0, 2);
    repeat (8) applyStimulus(1, 1, 0, 0, 0, 0, 2);
    applyStimulus(1, 0, 0, 0, 0, 0, 2);

    // Randomized traffic.
    run_lvl = 1'b0;
    div_lvl = 1;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 39) == 0) run_lvl = ~run_lvl;
      if ($urandom_range(0, 19) == 0) div_lvl = $urandom_range(0, 5);
      applyStimulus($urandom_range(0, 299) != 0,
                    run_lvl,
                    $urandom_range(0, 29) == 0,
                    $urandom_range(0, 9) == 0,
                    $urandom_range(0, 11) == 0,
                    $urandom_range(0, 8),
                    div_lvl);
    end
    applyStimulus(1, 0, 1, 0, 0, 0, 1);

    // Let the monitor drain the last expectations, bounded by a cycle budget.
    pending = 0;
    while (sb_queue.size() > 0 && pending < 10) begin
      @(posedge clk_in);
      #3;
      pending++;
    end
    if (sb_queue.size() != 0) begin
      $display("[TB] FAIL drain: got %0d pending want 0", sb_queue.size());
      miscompares++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
